// File: rtl/ssd_mux_ctrl.sv
// Scan controller for a dual seven-segment display sharing one decoder.
// Sequence: BLANK1 -> SHOW1 -> BLANK2 -> SHOW2. Digit codes are captured
// during BLANK1 and held for the whole frame, so a frame never tears.
// Optional feature: define SSD_ZERO_BLANK_EN to keep digit 2 dark while its
// code is zero (leading-zero suppression).
module ssd_mux_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 48000,
  parameter int unsigned BLANK_CYCLES   = 480,
  parameter int unsigned CNT_W          =
      $clog2(((REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s_1,
  input  logic [3:0] s_2,
  output logic [3:0] s,
  output logic       anode_1,
  output logic       anode_2,
  output logic       frame_done
);

  if (REFRESH_CYCLES < 2) begin : gen_refresh_range_chk
    $error("ssd_mux_ctrl: REFRESH_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : gen_blank_range_chk
    $error("ssd_mux_ctrl: BLANK_CYCLES must be >= 1");
  end

  // One-hot encoding so each anode is a single inverted state flop.
  typedef enum logic [3:0] {
    StBlank1 = 4'b0001,
    StShow1  = 4'b0010,
    StBlank2 = 4'b0100,
    StShow2  = 4'b1000
  } state_e;

  localparam logic [CNT_W-1:0] RefreshLast = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BlankLast   = CNT_W'(BLANK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sh1_q, sh1_d;
  logic [3:0]       sh2_q, sh2_d;
  logic [3:0]       s_q, s_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       state_bits;

  // Next-state, phase counter, shadow capture and registered-output precompute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      StBlank1: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow1;
          cnt_d   = '0;
        end
      end
      StShow1: begin
        if (cnt_q == RefreshLast) begin
          state_d = StBlank2;
          cnt_d   = '0;
        end
      end
      StBlank2: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow2;
          cnt_d   = '0;
        end
      end
      StShow2: begin
        if (cnt_q == RefreshLast) begin
          state_d = StBlank1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StBlank1;
        cnt_d   = '0;
      end
    endcase

    // Shadows track the inputs only while BLANK1 is active.
    sh1_d = (state_q == StBlank1) ? s_1 : sh1_q;
    sh2_d = (state_q == StBlank1) ? s_2 : sh2_q;

    // Decoder input follows the digit of the upcoming state, so it settles while blanked.
    s_d = ((state_d == StBlank1) || (state_d == StShow1)) ? sh1_d : sh2_d;

    frame_done_d = (state_d == StShow2) && (cnt_d == RefreshLast);
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StBlank1;
      cnt_q        <= '0;
      sh1_q        <= 4'h0;
      sh2_q        <= 4'h0;
      s_q          <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      s_q          <= s_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Anodes come straight from the state flops: glitch-free and mutually exclusive.
  always_comb begin
    state_bits = state_q;
    anode_1    = ~state_bits[1];
`ifdef SSD_ZERO_BLANK_EN
    anode_2    = ~state_bits[3] | (sh2_q == 4'h0);
`else
    anode_2    = ~state_bits[3];
`endif
  end

  assign s          = s_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_mux_ctrl.sv
// Self-checking bench for ssd_mux_ctrl with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// Digit codes expected for a frame are queued on the last BLANK1 cycle and
// popped when SHOW1 begins; timeline checks run every cycle.
module tb_ssd_mux_ctrl;

  localparam int Refresh = 8;
  localparam int Blank   = 2;
  localparam int Frame   = 2 * (Blank + Refresh);
`ifdef SSD_ZERO_BLANK_EN
  localparam bit ZeroBlank = 1'b1;
`else
  localparam bit ZeroBlank = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s_1 = 4'h0;
  logic [3:0] s_2 = 4'h0;
  logic [3:0] s;
  logic       anode_1;
  logic       anode_2;
  logic       frame_done;

  typedef struct packed {
    logic [3:0] c1;
    logic [3:0] c2;
  } frame_t;

  frame_t     sb_q[$];
  frame_t     popped;
  int         errors   = 0;
  int         checks   = 0;
  int         cyc      = 0;
  int         fd_count = 0;
  int         last_fd  = -1;
  logic [3:0] cur1     = 4'h0;
  logic [3:0] cur2     = 4'h0;

  always #5 clk = ~clk;

  ssd_mux_ctrl #(
    .REFRESH_CYCLES(Refresh),
    .BLANK_CYCLES  (Blank)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_1       (s_1),
    .s_2       (s_2),
    .s         (s),
    .anode_1   (anode_1),
    .anode_2   (anode_2),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int   ph;
    bit   in_show1;
    bit   in_show2;
    bit   second_half;
    logic exp_a2;
    ph          = cyc % Frame;
    in_show1    = (ph >= Blank) && (ph < Blank + Refresh);
    in_show2    = (ph >= 2 * Blank + Refresh);
    second_half = (ph >= Blank + Refresh);
    if (ph == Blank) begin
      chk("sb_depth", 8'(sb_q.size()), 8'd1);
      if (sb_q.size() > 0) begin
        popped = sb_q.pop_front();
        cur1   = popped.c1;
        cur2   = popped.c2;
      end
    end
    exp_a2 = !(in_show2 && !(ZeroBlank && (cur2 == 4'h0)));
    chk("anode_1", {7'd0, anode_1}, {7'd0, !in_show1});
    chk("anode_2", {7'd0, anode_2}, {7'd0, exp_a2});
    chk("frame_done", {7'd0, frame_done}, {7'd0, ph == Frame - 1});
    chk("no_overlap", {7'd0, anode_1 | anode_2}, 8'd1);
    if (in_show1) chk("s_digit1", {4'd0, s}, {4'd0, cur1});
    if (second_half) chk("s_digit2", {4'd0, s}, {4'd0, cur2});
  endtask

  task automatic step();
    check_cycle();
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("fd_spacing", 8'(cyc - last_fd), 8'(Frame));
      last_fd = cyc;
      fd_count++;
    end
    if (cyc % Frame == Blank - 1) sb_q.push_back('{c1: s_1, c2: s_2});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_anode_1", {7'd0, anode_1}, 8'd1);
      chk("rst_anode_2", {7'd0, anode_2}, 8'd1);
      chk("rst_s", {4'd0, s}, 8'd0);
      chk("rst_frame_done", {7'd0, frame_done}, 8'd0);
    end
    reset   = 1'b1;
    cyc     = 0;
    last_fd = -1;
    cur1    = 4'h0;
    cur2    = 4'h0;
    sb_q.delete();
    chk("s_cycle0", {4'd0, s}, 8'd0);
  endtask

  initial begin
    // Scenarios 1-3: reset, static codes, then a mid-SHOW1 change of s_1.
    s_1 = 4'h3;
    s_2 = 4'hA;
    do_reset(3);
    for (int i = 0; i < 2 * Frame; i++) begin
      if (cyc == 5) s_1 = 4'h7;
      step();
    end

    // Scenario 4: reset during SHOW2, then timeline restarts.
    while (cyc < Frame * 2 + 15) step();
    do_reset(2);

    // Scenario 5: zero code on digit 2.
    s_1 = 4'h5;
    s_2 = 4'h0;
    for (int i = 0; i < 2 * Frame; i++) step();

    // Scenario 6: random codes every cycle for 100 frames.
    fd_count = 0;
    for (int i = 0; i < 100 * Frame; i++) begin
      s_1 = 4'($urandom);
      s_2 = 4'($urandom);
      step();
    end
    chk("fd_pulse_count", 8'(fd_count), 8'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
